// File: rtl/sequence_store_if.sv
// sequence_store_if
//   Bundles the sequence-store request/read signals shared between the game
//   FSM / blinker side (master) and the sequence store (slave).
//   gen_start   master->slave  request a new random fill
//   stir        master->slave  player button activity, perturbs the LFSR
//   rd_addr     master->slave  read address (blinker count)
//   gen_busy    slave->master  high while filling
//   gen_done    slave->master  one-cycle pulse when the fill completes
//   led_to_glow slave->master  entry at rd_addr
interface sequence_store_if;
    logic       gen_start;
    logic       stir;
    logic [3:0] rd_addr;
    logic       gen_busy;
    logic       gen_done;
    logic [1:0] led_to_glow;

    modport master (
        output gen_start, stir, rd_addr,
        input  gen_busy, gen_done, led_to_glow
    );

    modport slave (
        input  gen_start, stir, rd_addr,
        output gen_busy, gen_done, led_to_glow
    );
endinterface

// File: rtl/sequence_store.sv
// sequence_store
//   Generates and holds the Simon Says colour sequence (one 2-bit LED code per
//   step). A free-running 8-bit LFSR, stirred by button activity, supplies the
//   random candidates; a small IDLE -> FILL -> DONE machine writes DEPTH
//   entries on request. Reads are combinational.
// Ports
//   clk    system clock
//   reset  asynchronous, active-high reset (clears LFSR, FSM and memory)
//   bus    sequence_store_if.slave: gen_start, stir, rd_addr in;
//          gen_busy, gen_done, led_to_glow out
// Parameters
//   DEPTH  number of entries, 1..16
//   SEED   LFSR reset/reload value, nonzero
// Build option
//   SEQ_NO_REPEAT_EN  when defined, an entry equal to its predecessor is
//                     bumped by one (mod 4) so no two consecutive entries match.
module sequence_store #(
    parameter int         DEPTH = 16,
    parameter logic [7:0] SEED  = 8'hA5
) (
    input  logic             clk,
    input  logic             reset,
    sequence_store_if.slave  bus
);

    localparam logic [3:0] LAST = 4'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [7:0]  lfsr, lfsr_nxt;
    logic [3:0]  k, k_nxt;
    logic        wr_en;
    logic [1:0]  wr_data;
    logic [1:0]  cand;
    logic [1:0]  mem [16];

    // LFSR: taps 8,6,5,4 (maximal length). Stir flips the new LSB; a zero
    // result is replaced by SEED so the register can never lock up.
    always_comb begin
        lfsr_nxt = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        if (bus.stir)
            lfsr_nxt = lfsr_nxt ^ 8'h01;
        if (lfsr_nxt == 8'h00)
            lfsr_nxt = SEED;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            lfsr <= SEED;
        else
            lfsr <= lfsr_nxt;
    end

    // Candidate is taken from the value the LFSR holds before this edge.
    assign cand = lfsr[1:0];

    always_comb begin
        wr_data = cand;
`ifdef SEQ_NO_REPEAT_EN
        // mem[k-1] was written on the previous edge, so it already holds the
        // final value of the preceding entry.
        if (k != 4'd0 && cand == mem[k - 4'd1])
            wr_data = cand + 2'd1;
`endif
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            k     <= 4'd0;
        end else begin
            state <= state_nxt;
            k     <= k_nxt;
        end
    end

    // FSM next-state / outputs
    always_comb begin
        state_nxt    = state;
        k_nxt        = k;
        wr_en        = 1'b0;
        bus.gen_busy = 1'b0;
        bus.gen_done = 1'b0;
        case (state)
            IDLE: begin
                if (bus.gen_start) begin
                    state_nxt = FILL;
                    k_nxt     = 4'd0;
                end
            end
            FILL: begin
                bus.gen_busy = 1'b1;
                wr_en        = 1'b1;
                if (k == LAST)
                    state_nxt = DONE;
                else
                    k_nxt = k + 4'd1;
            end
            DONE: begin
                // gen_start here is dropped, not queued.
                bus.gen_done = 1'b1;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Storage; unused entries above DEPTH stay at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++)
                mem[i] <= 2'b00;
        end else if (wr_en) begin
            mem[k] <= wr_data;
        end
    end

    // Zero-latency read; out-of-range addresses read as 0.
    assign bus.led_to_glow = ({28'd0, bus.rd_addr} < 32'(DEPTH)) ? mem[bus.rd_addr] : 2'b00;

endmodule

// File: tb/tb_sequence_store.sv
module tb_sequence_store;

    localparam int         DEPTH = 16;
    localparam logic [7:0] SEED  = 8'hA5;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #10 clk = ~clk;

    sequence_store_if bus();

    sequence_store #(.DEPTH(DEPTH), .SEED(SEED)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0] m_lfsr;
    logic [1:0] exp_mem [16];
    logic [31:0] seq1_dut, seq1_exp;

    // Reference LFSR step: x^8+x^6+x^5+x^4+1, stir XOR into bit 0, zero -> SEED
    function automatic logic [7:0] step(input logic [7:0] v, input logic s);
        logic [7:0] n;
        n = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
        if (s) n[0] = ~n[0];
        if (n == 8'h00) n = SEED;
        return n;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) m_lfsr <= SEED;
        else       m_lfsr <= step(m_lfsr, bus.stir);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // LFSR tracks the model every cycle and never reaches zero.
    always @(negedge clk) begin
        if (!reset) begin
            chk("lfsr_model", {24'd0, dut.lfsr}, {24'd0, m_lfsr});
            total++;
            assert (dut.lfsr !== 8'h00) else begin
                bad++;
                $error("FAIL lfsr_zero observed=%0h expected=nonzero", dut.lfsr);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected fill contents given the LFSR value and stir at the sampling edge.
    task automatic build_exp(input logic [7:0] l0, input logic s0);
        logic [7:0] cur;
        logic       s;
        logic [1:0] c;
        cur = l0;
        s   = s0;
        for (int i = 0; i < DEPTH; i++) begin
            cur = step(cur, s);
            s   = 1'b0;
            c   = cur[1:0];
`ifdef SEQ_NO_REPEAT_EN
            if (i > 0 && c == exp_mem[i-1]) c = c + 2'd1;
`endif
            exp_mem[i] = c;
        end
    endtask

    task automatic check_mem(input string tag);
        logic [1:0] prev;
        prev = 2'b00;
        for (int a = 0; a < DEPTH; a++) begin
            bus.rd_addr = 4'(a);
            #1;
            chk(tag, {30'd0, bus.led_to_glow}, {30'd0, exp_mem[a]});
`ifdef SEQ_NO_REPEAT_EN
            if (a > 0) chk({tag, "_norep"}, {31'd0, bus.led_to_glow != prev}, 32'd1);
`endif
            prev = bus.led_to_glow;
        end
        bus.rd_addr = 4'd0;
    endtask

    function automatic logic [31:0] pack_exp();
        logic [31:0] p;
        p = '0;
        for (int i = 0; i < 16; i++) p[2*i +: 2] = exp_mem[i];
        return p;
    endfunction

    task automatic read_dut(output logic [31:0] p);
        p = '0;
        for (int a = 0; a < 16; a++) begin
            bus.rd_addr = 4'(a);
            #1;
            p[2*a +: 2] = bus.led_to_glow;
        end
        bus.rd_addr = 4'd0;
    endtask

    task automatic wait_done(input string tag);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            if (bus.gen_done) got = 1'b1;
            else tick();
        end
        chk(tag, {31'd0, got}, 32'd1);
    endtask

    initial begin
        int busy_n, done_n;
        logic [7:0] l;
        logic       s;
        logic [31:0] seq5_dut, seq5_exp;

        bus.gen_start = 1'b0;
        bus.stir      = 1'b0;
        bus.rd_addr   = 4'd0;
        repeat (2) @(posedge clk);
        #1;

        // ---- reset state
        chk("rst_busy", {31'd0, bus.gen_busy}, 32'd0);
        chk("rst_done", {31'd0, bus.gen_done}, 32'd0);
        chk("rst_led",  {30'd0, bus.led_to_glow}, 32'd0);
        chk("rst_lfsr", {24'd0, dut.lfsr}, 32'h0000_00A5);

        // ---- test 1: fill from SEED, exact busy/done timing
        build_exp(SEED, 1'b0);
        seq1_exp      = pack_exp();
        bus.gen_start = 1'b1;
        reset         = 1'b0;
        tick();
        bus.gen_start = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            chk("t1_busy", {31'd0, bus.gen_busy}, 32'd1);
            chk("t1_nodone", {31'd0, bus.gen_done}, 32'd0);
            tick();
        end
        chk("t1_done_hi", {31'd0, bus.gen_done}, 32'd1);
        chk("t1_busy_lo", {31'd0, bus.gen_busy}, 32'd0);
        tick();
        chk("t1_done_lo", {31'd0, bus.gen_done}, 32'd0);
        bus.rd_addr = 4'd0; #1; chk("t1_mem0", {30'd0, bus.led_to_glow}, 32'd2);
        bus.rd_addr = 4'd1; #1; chk("t1_mem1", {30'd0, bus.led_to_glow}, 32'd1);
        bus.rd_addr = 4'd2; #1; chk("t1_mem2", {30'd0, bus.led_to_glow}, 32'd2);
        read_dut(seq1_dut);

        // ---- test 2: sweep against model, then again after idle cycles
        check_mem("t2_sweep");
        repeat (5) tick();
        check_mem("t2_hold");

        // ---- test 3: gen_start in FILL and DONE is ignored
        build_exp(m_lfsr, 1'b0);
        bus.gen_start = 1'b1;
        tick();
        bus.gen_start = 1'b0;
        busy_n = 0;
        done_n = 0;
        for (int i = 0; i < 24; i++) begin
            if (bus.gen_busy) busy_n++;
            if (bus.gen_done) done_n++;
            bus.gen_start = (i == 5) || bus.gen_done;
            tick();
        end
        bus.gen_start = 1'b0;
        chk("t3_busy_cycles", 32'(busy_n), 32'd16);
        chk("t3_done_count",  32'(done_n), 32'd1);
        check_mem("t3_mem");

        // ---- test 4: reset at FILL cycle 7
        bus.gen_start = 1'b1;
        tick();
        bus.gen_start = 1'b0;
        repeat (7) tick();
        chk("t4_busy_pre", {31'd0, bus.gen_busy}, 32'd1);
        reset = 1'b1;
        #1;
        chk("t4_busy", {31'd0, bus.gen_busy}, 32'd0);
        chk("t4_done", {31'd0, bus.gen_done}, 32'd0);
        chk("t4_lfsr", {24'd0, dut.lfsr}, 32'h0000_00A5);
        for (int a = 0; a < 16; a++) begin
            bus.rd_addr = 4'(a);
            #1;
            chk("t4_clear", {30'd0, bus.led_to_glow}, 32'd0);
        end
        bus.rd_addr = 4'd0;
        tick();
        reset  = 1'b0;
        busy_n = 0;
        done_n = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.gen_busy) busy_n++;
            if (bus.gen_done) done_n++;
            tick();
        end
        chk("t4_no_busy", 32'(busy_n), 32'd0);
        chk("t4_no_done", 32'(done_n), 32'd0);

        // ---- test 5: one stir cycle in IDLE, then a fill
        bus.stir = 1'b1;
        tick();
        bus.stir = 1'b0;
        build_exp(m_lfsr, 1'b0);
        seq5_exp      = pack_exp();
        bus.gen_start = 1'b1;
        tick();
        bus.gen_start = 1'b0;
        wait_done("t5_done");
        check_mem("t5_mem");
        read_dut(seq5_dut);
        chk("t5_differs", {31'd0, seq5_dut != seq1_dut}, {31'd0, seq5_exp != seq1_exp});

        // ---- test 6: 50 fills with random stir
        for (int f = 0; f < 50; f++) begin
            repeat (3) begin
                bus.stir = 1'($urandom_range(0, 1));
                tick();
            end
            s             = 1'($urandom_range(0, 1));
            l             = m_lfsr;
            bus.stir      = s;
            bus.gen_start = 1'b1;
            build_exp(l, s);
            tick();
            bus.stir      = 1'b0;
            bus.gen_start = 1'b0;
            wait_done("t6_done");
            check_mem("t6_mem");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
